// File: rtl/cache_pkg.sv
// Shared cache types: lookup FSM states, address field types, default widths.
package cache_pkg;

  localparam int INDEX_WIDTH_DEF  = 6;
  localparam int TAG_SIZE_DEF     = 20;
  localparam int OFFSET_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF   =
    TAG_SIZE_DEF + INDEX_WIDTH_DEF + OFFSET_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    UPDATE
  } lookup_state_t;

  typedef logic [TAG_SIZE_DEF-1:0]     tag_t;
  typedef logic [INDEX_WIDTH_DEF-1:0]  index_t;
  typedef logic [OFFSET_WIDTH_DEF-1:0] offset_t;

  typedef struct packed {
    tag_t    tag;
    index_t  index;
    offset_t offset;
  } cache_addr_t;

endpackage

// File: rtl/valid_bit_array.sv
// Per-line valid flags: set one line by index, clear all (clear wins),
// combinational read of the flop array.
module valid_bit_array #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_i,
  input  logic [INDEX_WIDTH-1:0] set_index_i,
  input  logic                   clear_all_i,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  output logic                   rd_valid_o
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (set_i) begin
      valid_q[set_index_i] <= 1'b1;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/tag_lookup_unit.sv
// Cache tag lookup stage: hit/miss check, refill request, tag write-back.
// Optional TAG_LOOKUP_STATS_EN adds 32-bit hit/miss counters.
module tag_lookup_unit
  import cache_pkg::*;
#(
  parameter int  INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int  TAG_SIZE     = TAG_SIZE_DEF,
  parameter int  OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  localparam int ADDR_WIDTH   = TAG_SIZE + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  req_address_i,
  output logic                   req_ready_o,
  input  logic                   flush_i,
  output logic [INDEX_WIDTH-1:0] tag_address_o,
  output logic                   tag_read_o,
  output logic                   tag_write_o,
  output logic [TAG_SIZE-1:0]    tag_write_data_o,
  input  logic [TAG_SIZE-1:0]    tag_read_data_i,
  output logic                   refill_req_o,
  output logic [ADDR_WIDTH-1:0]  refill_address_o,
  input  logic                   refill_done_i,
  output logic                   resp_valid_o,
  output logic                   hit_o
`ifdef TAG_LOOKUP_STATS_EN
  ,
  output logic [31:0]            hit_count_o,
  output logic [31:0]            miss_count_o
`endif
);

  lookup_state_t state_q, state_d;

  logic [TAG_SIZE-1:0]    tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [TAG_SIZE-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0] req_index;

  logic req_ready_q;
  logic resp_valid_q;
  logic hit_q;
  logic refill_req_q;
  logic [ADDR_WIDTH-1:0] refill_addr_q;

  logic accept;
  logic flush_apply;
  logic line_valid;
  logic lookup_hit;
  logic valid_set;

  assign req_tag   = req_address_i[ADDR_WIDTH-1 -: TAG_SIZE];
  assign req_index = req_address_i[OFFSET_WIDTH +: INDEX_WIDTH];

  // Flush wins over a simultaneous request.
  assign flush_apply = (state_q == IDLE) && flush_i;
  assign accept      = (state_q == IDLE) && req_valid_i && !flush_i;
  assign lookup_hit  = line_valid && (tag_read_data_i == tag_q);

  valid_bit_array #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_valid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (valid_set),
    .set_index_i (index_q),
    .clear_all_i (flush_apply),
    .rd_index_i  (index_q),
    .rd_valid_o  (line_valid)
  );

  always_comb begin
    state_d          = state_q;
    tag_read_o       = 1'b0;
    tag_write_o      = 1'b0;
    tag_address_o    = '0;
    tag_write_data_o = '0;
    valid_set        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tag_read_o    = 1'b1;
          tag_address_o = req_index;
          state_d       = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = lookup_hit ? IDLE : REFILL;
      end
      REFILL: begin
        if (refill_done_i) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        tag_write_o      = 1'b1;
        tag_address_o    = index_q;
        tag_write_data_o = tag_q;
        valid_set        = 1'b1;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      index_q       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      hit_q         <= 1'b0;
      refill_req_q  <= 1'b0;
      refill_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == IDLE);
      refill_req_q <= (state_d == REFILL);
      hit_q        <= (state_q == LOOKUP) && lookup_hit;
      // Response strobe lands one cycle after the deciding cycle.
      resp_valid_q <= ((state_q == LOOKUP) && lookup_hit) ||
                      ((state_q == REFILL) && refill_done_i);
      if (accept) begin
        tag_q   <= req_tag;
        index_q <= req_index;
      end
      if ((state_q == LOOKUP) && !lookup_hit) begin
        refill_addr_q <= {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
      end
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign hit_o            = hit_q;
  assign refill_req_o     = refill_req_q;
  assign refill_address_o = refill_addr_q;

`ifdef TAG_LOOKUP_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_apply) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_valid_q) begin
      if (hit_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule
